ahb_manager_port: RTL

- AHB-Lite manager (initiator) for the status/payload/data-size subordinate register block.
- Turns a simple valid/ready command stream into single NONSEQ transfers, with pipelined address and data phases, wait-state handling and two-cycle ERROR handling.
- Returns one in-order response per command: read data, right-aligned, plus an error flag.
- Sits between the local controller and the AHB-Lite interconnect. The decoder drives hsel_x; this block does not.

---
 rtl/ahb_pkg.sv | 24 ++
 rtl/ahb_lane_align.sv | 35 +++
 rtl/ahb_manager_port.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the register-block address map used by the
// manager port and its lane-alignment helper.
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      NONSEQ = 2'd2,
      SEQ    = 2'd3
   } htrans_t;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   // Subordinate register block address map.
   localparam logic [2:0] ERR_STATUS_ADDR = 3'd1;
   localparam logic [2:0] PAYLOAD_ADDR    = 3'd2;
   localparam logic [2:0] DATA_SIZE_ADDR  = 3'd4;

   localparam logic OKAY  = 1'b0;
   localparam logic ERROR = 1'b1;

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane helper for a 32-bit AHB data bus. With extract=0 it places
// right-aligned write data onto its byte lanes; with extract=1 it pulls the
// addressed lanes of a read bus down to bit 0 and zero-extends them.
module ahb_lane_align
   import ahb_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [1:0]            offset,
   input  logic [2:0]            size,
   input  logic                  extract,
   output logic [DATA_WIDTH-1:0] result
);

   logic [DATA_WIDTH-1:0] size_mask;
   logic [4:0]            shift;

   // Size mask and lane shift, then either place or extract.
   always_comb begin
      size_mask = '1;
      if (size == HSIZE_BYTE) begin
         size_mask = DATA_WIDTH'(32'h0000_00FF);
      end else if (size == HSIZE_HALF) begin
         size_mask = DATA_WIDTH'(32'h0000_FFFF);
      end
      shift = {offset, 3'b000};
      if (extract) begin
         result = (data >> shift) & size_mask;
      end else begin
         result = (data & size_mask) << shift;
      end
   end

endmodule

// File: rtl/ahb_manager_port.sv
// AHB-Lite manager port: converts a valid/ready command stream into single
// NONSEQ transfers with overlapped address (A) and data (D) phases, and
// returns one in-order response per command.
//
// Handshake: a command transfers on any rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high whenever the address slot is
// free or the bus is advancing (hready). rsp_valid is a single-cycle pulse
// with no back-pressure, so the consumer must take it when it appears.
module ahb_manager_port
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH    = 3,
   parameter int DATA_WIDTH    = 32,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     hclk,
   input  logic                     hresetn,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_write,
   input  logic [ADDR_WIDTH-1:0]    cmd_addr,
   input  logic [2:0]               cmd_size,
   input  logic [DATA_WIDTH-1:0]    cmd_wdata,
   output logic                     rsp_valid,
   output logic [DATA_WIDTH-1:0]    rsp_rdata,
   output logic                     rsp_err,
   output logic [ERR_CNT_WIDTH-1:0] err_count,
   output logic [1:0]               htrans,
   output logic [ADDR_WIDTH-1:0]    haddr,
   output logic                     hwrite,
   output logic [2:0]               hsize,
   output logic [DATA_WIDTH-1:0]    hwdata,
   input  logic                     hready,
   input  logic                     hresp,
   input  logic [DATA_WIDTH-1:0]    hrdata
);

   // Address-phase slot: haddr/hwrite/hsize are the slot's own registers.
   logic                  a_valid;
   logic [DATA_WIDTH-1:0] a_wdata;
   // Data-phase slot: only what is needed to shape the response.
   logic                  d_valid;
   logic                  d_write;
   logic [1:0]            d_off;
   logic [2:0]            d_size;

   logic                  accept;
   logic [DATA_WIDTH-1:0] wr_lane;
   logic [DATA_WIDTH-1:0] rd_lane;

   assign cmd_ready = hresetn & (~a_valid | hready);
   assign accept    = cmd_valid & cmd_ready;
   assign htrans    = a_valid ? NONSEQ : IDLE;

   ahb_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_wr_align (
      .data    (a_wdata),
      .offset  (haddr[1:0]),
      .size    (hsize),
      .extract (1'b0),
      .result  (wr_lane)
   );

   ahb_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_rd_align (
      .data    (hrdata),
      .offset  (d_off),
      .size    (d_size),
      .extract (1'b1),
      .result  (rd_lane)
   );

   // Address slot: load on acceptance, drain when the bus advances with nothing new.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         a_valid <= 1'b0;
         a_wdata <= '0;
         haddr   <= '0;
         hwrite  <= 1'b0;
         hsize   <= 3'd0;
      end else if (accept) begin
         a_valid <= 1'b1;
         a_wdata <= cmd_wdata;
         haddr   <= cmd_addr;
         hwrite  <= cmd_write;
         hsize   <= cmd_size;
      end else if (hready) begin
         a_valid <= 1'b0;
      end
   end

   // Data slot and response: on each bus advance, complete D and move A into D.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         d_valid   <= 1'b0;
         d_write   <= 1'b0;
         d_off     <= 2'd0;
         d_size    <= 3'd0;
         hwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         err_count <= '0;
      end else if (hready) begin
         rsp_valid <= d_valid;
         rsp_err   <= d_valid & (hresp == ERROR);
         rsp_rdata <= (d_valid && !d_write) ? rd_lane : '0;
         if (d_valid && (hresp == ERROR) && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
         end
         d_valid <= a_valid;
         d_write <= hwrite;
         d_off   <= haddr[1:0];
         d_size  <= hsize;
         if (a_valid) begin
            hwdata <= wr_lane;
         end
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end
   end

endmodule
